// File: rtl/cpld_link_ctrl.sv
// cpld_link_ctrl: continuous 16-bit full-duplex serial link to a CPLD.
// Frames of 16 bits are shifted LSB first with no gap between frames; the
// last bit period of every frame is marked by cpld_load. One word can be
// queued in a pending slot; without a new word the previous one repeats.
// Optional feature: define CPLD_LINK_RX_CHANGE_EN to enable rx_changed,
// a pulse marking a received frame that differs from the previous one.
module cpld_link_ctrl #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int SCLK_HZ     = 1600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        rx_changed,
   output logic        cpld_clk,
   output logic        cpld_load,
   output logic        cpld_mosi,
   input  logic        cpld_miso
);

   // Half period of cpld_clk in system clocks; must be at least 2.
   localparam int DIV = CLK_FREQ_HZ / (2 * SCLK_HZ);
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  tick_cnt_reg, tick_cnt_next;
   logic              tick;
   logic [3:0]        bit_idx_reg, bit_idx_next;
   logic [15:0]       active_reg, active_next;
   logic [15:0]       pending_reg;
   logic              pending_full_reg;
   logic [15:0]       rx_shift_reg, rx_shift_next;
   logic [15:0]       rx_data_reg;
   logic              rx_valid_reg;
   logic              miso_reg;
   logic              mosi_reg, mosi_next;
   logic              sample_en;     // low->high tick: capture a receive bit
   logic              shift_out_en;  // high->low tick: present next transmit bit
   logic              boundary;      // high->low tick that ends bit 15
   logic              handshake;

   // Tick counter: one tick every DIV cycles, first tick DIV-1 cycles after reset.
   assign tick = (tick_cnt_reg == '0);

   always_comb begin
      tick_cnt_next = tick ? CNT_RELOAD : tick_cnt_reg - 1'b1;
   end

   // Tick counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_reg <= CNT_RELOAD;
      end else begin
         tick_cnt_reg <= tick_cnt_next;
      end
   end

   // Next-state logic: each tick flips the clock phase; bit index advances on the falling phase.
   always_comb begin
      state_next   = state_reg;
      bit_idx_next = bit_idx_reg;
      sample_en    = 1'b0;
      shift_out_en = 1'b0;
      boundary     = 1'b0;
      case (state_reg)
         ST_LOW: begin
            if (tick) begin
               state_next = ST_HIGH;
               sample_en  = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tick) begin
               state_next   = ST_LOW;
               shift_out_en = 1'b1;
               if (bit_idx_reg == 4'd15) begin
                  boundary     = 1'b1;
                  bit_idx_next = 4'd0;
               end else begin
                  bit_idx_next = bit_idx_reg + 4'd1;
               end
            end
         end
         default: begin
            state_next = ST_LOW;
         end
      endcase
   end

   // State and bit index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_LOW;
         bit_idx_reg <= 4'd0;
      end else begin
         state_reg   <= state_next;
         bit_idx_reg <= bit_idx_next;
      end
   end

   // The pending word replaces the active word only at a frame boundary.
   assign active_next = (boundary && pending_full_reg) ? pending_reg : active_reg;

   // MOSI presents the bit of the upcoming bit period; at a boundary that is bit 0 of the new word.
   always_comb begin
      mosi_next = mosi_reg;
      if (shift_out_en) begin
         mosi_next = active_next[bit_idx_next];
      end
   end

   // Active word and MOSI registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_reg <= 16'h0000;
         mosi_reg   <= 1'b0;
      end else begin
         active_reg <= active_next;
         mosi_reg   <= mosi_next;
      end
   end

   // The slot is never offered during reset. A handshake cannot coincide with the
   // boundary clear (it needs an empty slot), so a word written on the boundary
   // cycle simply waits for the following frame.
   assign tx_ready  = ~pending_full_reg & ~rst;
   assign handshake = tx_valid & tx_ready;

   // Pending slot: filled by the handshake, emptied when a boundary consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg      <= 16'h0000;
         pending_full_reg <= 1'b0;
      end else begin
         if (boundary && pending_full_reg) begin
            pending_full_reg <= 1'b0;
         end
         if (handshake) begin
            pending_reg      <= tx_data;
            pending_full_reg <= 1'b1;
         end
      end
   end

   // Receive shift register: shift right with the new bit entering at the MSB,
   // so after 16 samples the first received bit sits at bit 0.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_rx_shift
         if (gi == 15) begin : g_msb
            assign rx_shift_next[gi] = sample_en ? miso_reg : rx_shift_reg[gi];
         end else begin : g_lower
            assign rx_shift_next[gi] = sample_en ? rx_shift_reg[gi+1] : rx_shift_reg[gi];
         end
      end
   endgenerate

   // MISO synchroniser stage and receive path registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         miso_reg     <= 1'b0;
         rx_shift_reg <= 16'h0000;
         rx_data_reg  <= 16'h0000;
         rx_valid_reg <= 1'b0;
      end else begin
         miso_reg     <= cpld_miso;
         rx_shift_reg <= rx_shift_next;
         rx_valid_reg <= boundary;
         if (boundary) begin
            rx_data_reg <= rx_shift_reg;
         end
      end
   end

`ifdef CPLD_LINK_RX_CHANGE_EN
   logic [15:0] prev_frame_reg;
   logic        rx_changed_reg;

   // Change detector: compare each completed frame against the one before it.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_frame_reg <= 16'h0000;
         rx_changed_reg <= 1'b0;
      end else begin
         rx_changed_reg <= boundary && (rx_shift_reg != prev_frame_reg);
         if (boundary) begin
            prev_frame_reg <= rx_shift_reg;
         end
      end
   end

   assign rx_changed = rx_changed_reg;
`else
   assign rx_changed = 1'b0;
`endif

   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign cpld_clk  = (state_reg == ST_HIGH);
   assign cpld_load = (bit_idx_reg == 4'd15);
   assign cpld_mosi = mosi_reg;

endmodule

// File: tb/tb_cpld_link_ctrl.sv
// Testbench for cpld_link_ctrl with DIV = 2 (64-cycle frames).
// Every cycle all outputs are compared against a frame-arithmetic reference
// model; on top of that a vector table, a few hand-written corner sequences
// and a randomized phase are run.
module tb_cpld_link_ctrl;

   localparam int CLK_FREQ_HZ = 16;
   localparam int SCLK_HZ     = 4;
   localparam int DIV         = CLK_FREQ_HZ / (2 * SCLK_HZ);
   localparam int BITP        = 2 * DIV;
   localparam int FRAME       = 32 * DIV;
   localparam int NV          = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] tx_data = 16'h0000;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_changed;
   logic        cpld_clk;
   logic        cpld_load;
   logic        cpld_mosi;
   logic        cpld_miso = 1'b0;

   cpld_link_ctrl #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .SCLK_HZ    (SCLK_HZ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_changed(rx_changed),
      .cpld_clk  (cpld_clk),
      .cpld_load (cpld_load),
      .cpld_mosi (cpld_mosi),
      .cpld_miso (cpld_miso)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Values sampled from the DUT in the most recent cycle.
   logic        s_clk, s_load, s_mosi, s_ready, s_valid, s_chg;
   logic [15:0] s_data;

   // Reference model: mc counts cycles since the last reset edge.
   bit          m_ok = 1'b0;
   int          mc = 0;
   logic [15:0] m_word = '0;      // word transmitted in the current frame
   logic [15:0] m_pend = '0;
   bit          m_full = 1'b0;
   logic [15:0] m_rx_acc = '0;    // bits received so far in this frame
   logic [15:0] m_rx_data = '0;
   bit          m_valid = 1'b0;
   bit          m_chg = 1'b0;
   logic        m_miso_prev = 1'b0;
   logic        idle_miso = 1'b1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model mid-cycle,
   // then advance the model across the rising edge.
   task automatic tick(input logic r, input logic txv, input logic [15:0] txd, input logic mi);
      int n;
      int b;
      bit hs;
      rst       = r;
      tx_valid  = txv;
      tx_data   = txd;
      cpld_miso = mi;
      @(negedge clk);
      s_clk   = cpld_clk;
      s_load  = cpld_load;
      s_mosi  = cpld_mosi;
      s_ready = tx_ready;
      s_valid = rx_valid;
      s_chg   = rx_changed;
      s_data  = rx_data;
      if (m_ok) begin
         n = mc / DIV;
         b = (n / 2) % 16;
         check("cpld_clk", s_clk, 16'(n % 2));
         check("cpld_load", s_load, 16'(b == 15));
         check("cpld_mosi", s_mosi, 16'(m_word[b]));
         check("tx_ready", s_ready, 16'(!r && !m_full));
         check("rx_valid", s_valid, 16'(m_valid));
         check("rx_data", s_data, m_rx_data);
         check("rx_changed", s_chg, 16'(m_chg));
      end
      if (s_valid === 1'b1)
         $display("rx frame %h changed=%b at %0t", s_data, s_chg, $time);
      @(posedge clk);
      if (r) begin
         m_ok = 1'b1;
         mc = 0;
         m_word = '0;
         m_full = 1'b0;
         m_rx_acc = '0;
         m_rx_data = '0;
         m_valid = 1'b0;
         m_chg = 1'b0;
      end else begin
         n = mc / DIV;
         hs = txv && !m_full;
         m_valid = 1'b0;
         m_chg = 1'b0;
         if ((mc % DIV) == DIV - 1) begin
            if ((n % 2) == 0)
               m_rx_acc[(n / 2) % 16] = m_miso_prev;
            if ((n % 32) == 31) begin
               m_valid = 1'b1;
`ifdef CPLD_LINK_RX_CHANGE_EN
               m_chg = (m_rx_acc != m_rx_data);
`endif
               m_rx_data = m_rx_acc;
               if (m_full) begin
                  m_word = m_pend;
                  m_full = 1'b0;
               end
            end
         end
         if (hs) begin
            m_pend = txd;
            m_full = 1'b1;
         end
         mc++;
      end
      m_miso_prev = mi;
      #1;
   endtask

   task automatic tick_idle();
      tick(1'b0, 1'b0, 16'h0000, idle_miso);
   endtask

   // Runs one whole frame from its first cycle, collecting the transmitted word.
   task automatic capture_frame(output logic [15:0] w, output int vcnt, output logic rdy0);
      int pos;
      w = '0;
      vcnt = 0;
      rdy0 = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         pos = mc % FRAME;
         tick_idle();
         if (i == 0) rdy0 = s_ready;
         if (s_valid === 1'b1) vcnt++;
         if ((pos % BITP) == DIV) w[pos / BITP] = s_mosi;
      end
   endtask

   typedef struct {
      logic        tx_en;
      logic [15:0] tx_word;
      logic [15:0] miso_word;
      logic [15:0] exp_mosi;
      logic [15:0] exp_rx;
      logic        exp_chg;   // expected rx_changed when the feature is built in
   } vec_t;

   vec_t        tbl [NV];
   logic [15:0] cap [NV];
   logic [15:0] rxg [NV];
   logic        chgg [NV];
   int          vc [NV];
   int          ldc [NV];
   int          tgc [NV];

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      int          f, pos, b;
      logic        mi, txv, prev_clk, rdy0, exp_c;
      logic [15:0] txd, w;
      int          vcnt;

      tbl[0] = '{1'b1, 16'hA5C3, 16'h8001, 16'h0000, 16'h8001, 1'b1};
      tbl[1] = '{1'b0, 16'h0000, 16'h1234, 16'hA5C3, 16'h1234, 1'b1};
      tbl[2] = '{1'b0, 16'h0000, 16'h1234, 16'hA5C3, 16'h1234, 1'b0};
      tbl[3] = '{1'b1, 16'h0F0F, 16'h0000, 16'hA5C3, 16'h0000, 1'b1};
      tbl[4] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hFFFF, 1'b1};
      tbl[5] = '{1'b1, 16'h1357, 16'hFFFF, 16'h0F0F, 16'hFFFF, 1'b0};
      tbl[6] = '{1'b0, 16'h0000, 16'h5A5A, 16'h1357, 16'h5A5A, 1'b1};
      for (int i = 0; i < NV; i++) begin
         cap[i] = '0; rxg[i] = '0; chgg[i] = 1'b0;
         vc[i] = 0; ldc[i] = 0; tgc[i] = 0;
      end

      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
      check("reset tx_ready", s_ready, 16'h0000);
      check("reset rx_data", s_data, 16'h0000);

      // Vector table: one frame per record, cycles counted from reset release.
      prev_clk = 1'b0;
      for (int cyc = 0; cyc <= NV * FRAME; cyc++) begin
         f   = cyc / FRAME;
         pos = cyc % FRAME;
         b   = pos / BITP;
         mi  = (f < NV) ? tbl[f].miso_word[b] : 1'b0;
         txv = (f < NV) ? (tbl[f].tx_en && (pos == 5 * BITP)) : 1'b0;
         txd = (f < NV) ? tbl[f].tx_word : 16'h0000;
         tick(1'b0, txv, txd, mi);
         if (f < NV) begin
            if (pos == b * BITP + DIV) cap[f][b] = s_mosi;
            if (s_load === 1'b1) ldc[f]++;
            if (pos != 0 && s_clk !== prev_clk) tgc[f]++;
         end
         if (s_valid === 1'b1 && f >= 1) begin
            vc[f-1]++;
            rxg[f-1]  = s_data;
            chgg[f-1] = s_chg;
         end
         if (f == 0 && pos == FRAME - 1) check("tx_ready low until boundary", s_ready, 16'h0000);
         if (f == 1 && pos == 0) check("tx_ready after boundary", s_ready, 16'h0001);
         prev_clk = s_clk;
      end
      for (int i = 0; i < NV; i++) begin
`ifdef CPLD_LINK_RX_CHANGE_EN
         exp_c = tbl[i].exp_chg;
`else
         exp_c = 1'b0;
`endif
         check($sformatf("vec%0d mosi", i), cap[i], tbl[i].exp_mosi);
         check($sformatf("vec%0d rx_data", i), rxg[i], tbl[i].exp_rx);
         check($sformatf("vec%0d rx_valid count", i), 16'(vc[i]), 16'd1);
         check($sformatf("vec%0d rx_changed", i), 16'(chgg[i]), 16'(exp_c));
         check($sformatf("vec%0d load cycles", i), 16'(ldc[i]), 16'(BITP));
         check($sformatf("vec%0d clk toggles", i), 16'(tgc[i]), 16'(FRAME / DIV - 1));
      end

      // Handshake exactly on the boundary cycle: old word first, new word next frame.
      while ((mc % FRAME) != FRAME - 1) tick_idle();
      tick(1'b0, 1'b1, 16'hC0DE, idle_miso);
      capture_frame(w, vcnt, rdy0);
      check("boundary hs tx_ready next cycle", 16'(rdy0), 16'h0000);
      check("boundary hs current frame", w, 16'h1357);
      capture_frame(w, vcnt, rdy0);
      check("boundary hs following frame", w, 16'hC0DE);

      // Reset at bit 7 with a word pending: frame aborted, pending discarded.
      while ((mc % FRAME) != 3 * BITP) tick_idle();
      tick(1'b0, 1'b1, 16'hBEEF, idle_miso);
      check("pre-reset rx_data", s_data, 16'hFFFF);
      while ((mc % FRAME) != 7 * BITP + 1) tick_idle();
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 16'h0000, idle_miso);
         if (k > 0) begin
            check("mid reset tx_ready", 16'(s_ready), 16'h0000);
            check("mid reset outputs", {10'd0, s_clk, s_load, s_mosi, s_valid, s_chg, 1'b0}, 16'h0000);
            check("mid reset rx_data", s_data, 16'h0000);
         end
      end
      capture_frame(w, vcnt, rdy0);
      check("post-reset frame mosi", w, 16'h0000);
      check("post-reset no rx_valid", 16'(vcnt), 16'h0000);
      check("post-reset tx_ready", 16'(rdy0), 16'h0001);
      tick_idle();
      check("post-reset first rx_valid", 16'(s_valid), 16'h0001);
      check("post-reset first rx_data", s_data, 16'hFFFF);
      while ((mc % FRAME) != 0) tick_idle();
      capture_frame(w, vcnt, rdy0);
      check("post-reset second frame mosi", w, 16'h0000);

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0),
              16'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpld_link_ctrl.md
CPLD_LINK_CTRL -- requirements
Module: cpld_link_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCLK_HZ, default 1600, cpld_clk frequency in Hz; DIV = CLK_FREQ_HZ/(2*SCLK_HZ), and DIV >= 2.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tx_data, input, 16, next frame word, shifted LSB first.
REQ-006 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-007 SHALL have port tx_ready, output, 1, pending slot empty.
REQ-008 SHALL have port rx_data, output, 16, last completed received frame.
REQ-009 SHALL have port rx_valid, output, 1, one-cycle pulse per completed frame.
REQ-010 SHALL have port rx_changed, output, 1, one-cycle pulse when the completed frame differs from the previous one (see REQ-027).
REQ-011 SHALL have port cpld_clk, output, 1, serial clock.
REQ-012 SHALL have port cpld_load, output, 1, frame-boundary strobe.
REQ-013 SHALL have port cpld_mosi, output, 1, serial data out.
REQ-014 SHALL have port cpld_miso, input, 1, serial data in; registered once before use.

Function
REQ-015 SHALL run a tick counter: load DIV-1, count down, assert tick at 0 and reload; tick period = DIV cycles.
REQ-016 SHALL toggle cpld_clk on every tick; bit period = 2 ticks, low half first.
REQ-017 SHALL use FSM states LOW (cpld_clk low) and HIGH (cpld_clk high), plus 4-bit bit index 0..15; a frame = 16 bit periods, with no gap between frames.
REQ-018 SHALL sample registered cpld_miso into the rx shift register (shift right, MSB in) on the tick taking cpld_clk low->high.
REQ-019 SHALL update cpld_mosi on the tick taking cpld_clk high->low, with active-word bit equal to the next bit index.
REQ-020 SHALL drive cpld_load high for the whole of bit period 15 and low otherwise.
REQ-021 SHALL, on the high->low tick ending bit 15 (frame boundary), pulse rx_valid for one cycle, copy the rx shift register to rx_data in the same cycle, reset the bit index to 0, and load the active word.
REQ-022 SHALL take the active word at a frame boundary from the pending register if it is full (then clear it), otherwise repeat the previous active word.
REQ-023 SHALL drive tx_ready = NOT pending_full; on tx_valid AND tx_ready, write tx_data to pending and set full; while full, tx_data is ignored.
REQ-024 SHALL give a handshake occurring on the frame-boundary cycle precedence over the clear: the word is stored in pending for the next frame and is not used for the current one, and tx_ready is low the following cycle.
REQ-025 SHALL make frame latency: a word accepted at least 1 cycle before a boundary appears on cpld_mosi starting at that boundary.

Reset
REQ-026 SHALL, while rst is high, set the following and restart at bit 0, LOW state, tick counter = DIV-1 on the first cycle after release (mid-frame reset aborts the frame with no rx_valid):
- tx_ready = 0 (gated)
- rx_data = 0x0000
- rx_valid = 0
- rx_changed = 0
- cpld_clk = 0
- cpld_load = 0
- cpld_mosi = 0
- active word = 0x0000
- pending empty
- rx shift register = 0

Configuration
REQ-027 SHALL, with macro CPLD_LINK_RX_CHANGE_EN defined, keep a 16-bit previous-frame register (reset 0x0000) and pulse rx_changed with rx_valid when the new rx_data differs from it.
REQ-028 SHALL, with CPLD_LINK_RX_CHANGE_EN undefined, tie rx_changed to 0 and omit the previous-frame register.

Verification (CLK_FREQ_HZ=16, SCLK_HZ=4, so DIV=2 and frame = 64 cycles)
REQ-029 SHALL verify that after reset release, cpld_clk toggles every 2 cycles, cpld_load is high for exactly 4 cycles per 64, and mosi is 16 zeros.
REQ-030 SHALL verify that tx_data=0xA5C3 accepted mid-frame leaves tx_ready low until the boundary; the next frame mosi = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; that frame is repeated when no new word is supplied.
REQ-031 SHALL verify that cpld_miso driven with frame 0x8001 (LSB first) gives rx_data=0x8001 and a single rx_valid pulse at the boundary.
REQ-032 SHALL verify that tx_valid held on the exact boundary cycle with pending empty sends the old word in the current frame and the new word in the following frame.
REQ-033 SHALL verify that rst asserted at bit 7 results in no rx_valid, all outputs 0, and the first post-reset frame starting at bit 0 with mosi all zeros.
REQ-034 SHALL verify that with CPLD_LINK_RX_CHANGE_EN and frames 0x1234, 0x1234, 0x0000, rx_changed pulses on frames 1 and 3 only; without the macro, rx_changed stays 0.
